// File: rtl/usb2_pkg.sv
// Shared USB 2.0 definitions: packer state encodings and buffer geometry.
// No logic, definitions only.
// Imported by the IN packer and its helpers.
package usb2_pkg;

    localparam int USB2_HS_BULK_MAX = 512;
    localparam int USB2_ADDR_W      = 9;
    localparam int USB2_LEN_W       = 10;

    typedef enum logic [1:0] {
        ST_WAIT_BUF = 2'd0,
        ST_FILL     = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_ACK_LO   = 2'd3
    } usb2_state_t;

endpackage

// File: rtl/usb2_sync2.sv
// Generic 2-flop synchronizer for a single level signal from another domain.
// Latency: 2 clk cycles.
// No backpressure; the input must be a slowly changing level.
module usb2_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/usb2_ext_in_packer.sv
// Packs an ext_clk byte stream into EP1 bulk IN packets in the endpoint buffer.
// Latency: accepted beat written one cycle later; commit one cycle after the FSM enters ST_COMMIT.
// Backpressure: s_ready is high only in ST_FILL; no beats accepted while waiting on buffer or ack.
module usb2_ext_in_packer
    import usb2_pkg::*;
#(
    parameter int MAX_PKT = USB2_HS_BULK_MAX,
    parameter int TIMEOUT = 1024
) (
    input  logic                   ext_clk,
    input  logic                   reset,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_last,
    input  logic                   flush,
    output logic [USB2_ADDR_W-1:0] ext_buf_in_addr,
    output logic [7:0]             ext_buf_in_data,
    output logic                   ext_buf_in_wren,
    input  logic                   ext_buf_in_ready,
    output logic                   ext_buf_in_commit,
    output logic [USB2_LEN_W-1:0]  ext_buf_in_commit_len,
    input  logic                   ext_buf_in_commit_ack,
    output logic [15:0]            pkt_count,
    output logic                   busy
);

    usb2_state_t           state, state_nxt;
    logic                  rdy_s, ack_s;
    logic [USB2_LEN_W-1:0] cnt, cnt_inc, len;
    logic [31:0]           idle;
    logic                  beat, end_beat, timeout_hit, ack_taken;

    usb2_sync2 u_sync_rdy (.clk(ext_clk), .rst(reset), .d(ext_buf_in_ready),      .q(rdy_s));
    usb2_sync2 u_sync_ack (.clk(ext_clk), .rst(reset), .d(ext_buf_in_commit_ack), .q(ack_s));

    assign s_ready   = (state == ST_FILL);
    assign beat      = s_valid & s_ready;
    assign cnt_inc   = cnt + 10'd1;
    // A flush that lands on a beat simply closes the packet after that byte.
    assign end_beat  = beat & ((cnt_inc == USB2_LEN_W'(MAX_PKT)) | s_last | flush);
    assign timeout_hit = (TIMEOUT != 0) && (cnt != '0) && (idle == 32'(TIMEOUT - 1));
    // Only count an ack once commit is actually being presented.
    assign ack_taken = (state == ST_COMMIT) & ext_buf_in_commit & ack_s;

    assign ext_buf_in_commit_len = len;
    assign busy = (state != ST_WAIT_BUF) || (cnt != '0);

    // State register.
    always_ff @(posedge ext_clk or posedge reset) begin
        if (reset) state <= ST_WAIT_BUF;
        else       state <= state_nxt;
    end

    // Next-state decode: beats take priority over flush and timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_BUF: if (rdy_s) state_nxt = ST_FILL;
            ST_FILL: begin
                if (beat) begin
                    if (end_beat) state_nxt = ST_COMMIT;
                end else if (flush || timeout_hit) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT:   if (ack_taken) state_nxt = ST_ACK_LO;
            ST_ACK_LO:   if (!ack_s) state_nxt = ST_WAIT_BUF;
            default:     state_nxt = ST_WAIT_BUF;
        endcase
    end

    // Byte count for the packet being filled and the length latched at close.
    always_ff @(posedge ext_clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            len <= '0;
        end else begin
            if (state == ST_WAIT_BUF && rdy_s) cnt <= '0;
            else if (beat)                     cnt <= cnt_inc;
            if (state == ST_FILL) begin
                if (end_beat)                            len <= cnt_inc;
                else if (!beat && (flush || timeout_hit)) len <= cnt;
            end
        end
    end

    // Idle counter: runs only while filling with no beat offered.
    always_ff @(posedge ext_clk or posedge reset) begin
        if (reset)                          idle <= '0;
        else if (state != ST_FILL || beat)  idle <= '0;
        else                                idle <= idle + 32'd1;
    end

    // Registered buffer write port; address and data hold between writes.
    always_ff @(posedge ext_clk or posedge reset) begin
        if (reset) begin
            ext_buf_in_wren <= 1'b0;
            ext_buf_in_addr <= '0;
            ext_buf_in_data <= '0;
        end else begin
            ext_buf_in_wren <= beat;
            if (beat) begin
                ext_buf_in_addr <= cnt[USB2_ADDR_W-1:0];
                ext_buf_in_data <= s_data;
            end
        end
    end

    // Commit rises the cycle after entering ST_COMMIT so it never overlaps the last write.
    always_ff @(posedge ext_clk or posedge reset) begin
        if (reset) begin
            ext_buf_in_commit <= 1'b0;
            pkt_count         <= '0;
        end else begin
            ext_buf_in_commit <= (state == ST_COMMIT) && !ack_taken;
            if (ack_taken) pkt_count <= pkt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_usb2_ext_in_packer.sv
// Directed bench for usb2_ext_in_packer with MAX_PKT=512, TIMEOUT=16.
// Drives inputs on the falling edge and samples outputs there or #1 after the rising edge.
// Acts as the endpoint: drops ready on commit, acks, then re-arms ready.
module tb_usb2_ext_in_packer;

    logic        ext_clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last = 1'b0;
    logic        flush = 1'b0;
    logic [8:0]  ext_buf_in_addr;
    logic [7:0]  ext_buf_in_data;
    logic        ext_buf_in_wren;
    logic        ext_buf_in_ready = 1'b0;
    logic        ext_buf_in_commit;
    logic [9:0]  ext_buf_in_commit_len;
    logic        ext_buf_in_commit_ack = 1'b0;
    logic [15:0] pkt_count;
    logic        busy;

    usb2_ext_in_packer #(.MAX_PKT(512), .TIMEOUT(16)) dut (
        .ext_clk               (ext_clk),
        .reset                 (reset),
        .s_data                (s_data),
        .s_valid               (s_valid),
        .s_ready               (s_ready),
        .s_last                (s_last),
        .flush                 (flush),
        .ext_buf_in_addr       (ext_buf_in_addr),
        .ext_buf_in_data       (ext_buf_in_data),
        .ext_buf_in_wren       (ext_buf_in_wren),
        .ext_buf_in_ready      (ext_buf_in_ready),
        .ext_buf_in_commit     (ext_buf_in_commit),
        .ext_buf_in_commit_len (ext_buf_in_commit_len),
        .ext_buf_in_commit_ack (ext_buf_in_commit_ack),
        .pkt_count             (pkt_count),
        .busy                  (busy)
    );

    always #5 ext_clk = ~ext_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Write-port and commit monitor, sampled just after each rising edge.
    int         wr_n = 0;
    int         overlap = 0;
    int         commit_rises = 0;
    logic       commit_q = 1'b0;
    logic [8:0] wr_addr [0:1023];
    logic [7:0] wr_data [0:1023];

    always @(posedge ext_clk) begin
        #1;
        if (ext_buf_in_wren) begin
            if (wr_n < 1024) begin
                wr_addr[wr_n] = ext_buf_in_addr;
                wr_data[wr_n] = ext_buf_in_data;
            end
            wr_n++;
            if (ext_buf_in_commit) overlap++;
        end
        if (ext_buf_in_commit && !commit_q) commit_rises++;
        commit_q = ext_buf_in_commit;
    end

    function automatic logic [7:0] pat(input int seed, input int i);
        return 8'(i * 7 + seed * 29 + 3);
    endfunction

    // Raise ready; FILL must be entered exactly three edges later.
    task automatic arm_ready(input string tag);
        ext_buf_in_ready = 1'b1;
        repeat (2) @(negedge ext_clk);
        check({tag, "_rdy_sync_lo"}, 32'(s_ready), 32'd0);
        @(negedge ext_clk);
        check({tag, "_rdy_sync_hi"}, 32'(s_ready), 32'd1);
    endtask

    task automatic send(input int seed, input int n, input bit last_on_end);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = pat(seed, i);
            s_last  = last_on_end && (i == n - 1);
            @(negedge ext_clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic check_writes(input string tag, input int base, input int seed, input int n);
        int bad;
        bad = 0;
        check({tag, "_wr_count"}, 32'(wr_n - base), 32'(n));
        for (int i = 0; i < n && base + i < 1024; i++)
            if (wr_addr[base + i] !== 9'(i) || wr_data[base + i] !== pat(seed, i)) bad++;
        check({tag, "_wr_bytes"}, 32'(bad), 32'd0);
    endtask

    // Endpoint side: wait for commit, take the buffer, ack for `hold` cycles.
    task automatic endpoint_ack(input string tag, input int exp_len, input int hold);
        int t;
        t = 0;
        while (!ext_buf_in_commit && t < 40) begin
            @(negedge ext_clk);
            t++;
        end
        check({tag, "_commit_seen"}, 32'(ext_buf_in_commit), 32'd1);
        ext_buf_in_ready = 1'b0;
        check({tag, "_commit_len"}, 32'(ext_buf_in_commit_len), 32'(exp_len));
        ext_buf_in_commit_ack = 1'b1;
        repeat (2) @(negedge ext_clk);
        check({tag, "_commit_held"}, 32'(ext_buf_in_commit), 32'd1);
        @(negedge ext_clk);
        check({tag, "_commit_fall"}, 32'(ext_buf_in_commit), 32'd0);
        repeat (hold - 3) @(negedge ext_clk);
        ext_buf_in_commit_ack = 1'b0;
        repeat (4) @(negedge ext_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rises;

        // Reset values.
        repeat (3) @(negedge ext_clk);
        check("rst_s_ready",    32'(s_ready), 0);
        check("rst_addr",       32'(ext_buf_in_addr), 0);
        check("rst_data",       32'(ext_buf_in_data), 0);
        check("rst_wren",       32'(ext_buf_in_wren), 0);
        check("rst_commit",     32'(ext_buf_in_commit), 0);
        check("rst_commit_len", 32'(ext_buf_in_commit_len), 0);
        check("rst_pkt_count",  32'(pkt_count), 0);
        check("rst_busy",       32'(busy), 0);
        reset = 1'b0;
        repeat (3) @(negedge ext_clk);
        check("no_rdy_no_accept", 32'(s_ready), 0);

        // Full 512-byte packet.
        arm_ready("full");
        check("full_busy", 32'(busy), 1);
        base = wr_n;
        send(1, 512, 1'b0);
        check("full_rdy_drop",  32'(s_ready), 0);
        check("full_last_wren", 32'(ext_buf_in_wren), 1);
        check("full_last_addr", 32'(ext_buf_in_addr), 511);
        check("full_no_commit_with_wr", 32'(ext_buf_in_commit), 0);
        endpoint_ack("full", 512, 10);
        check_writes("full", base, 1, 512);
        check("full_pkt_count", 32'(pkt_count), 1);
        repeat (20) @(negedge ext_clk);
        check("full_rdy_lo_hold", 32'(s_ready), 0);

        // Short packet, s_last on beat 37.
        arm_ready("short");
        base = wr_n;
        send(2, 37, 1'b1);
        endpoint_ack("short", 37, 10);
        check_writes("short", base, 2, 37);
        check("short_pkt_count", 32'(pkt_count), 2);

        // Flush outside FILL does nothing; flush at cnt=0 in FILL is a ZLP.
        flush = 1'b1;
        @(negedge ext_clk);
        flush = 1'b0;
        repeat (4) @(negedge ext_clk);
        check("flush_ignored", 32'(ext_buf_in_commit), 0);
        arm_ready("zlp");
        base = wr_n;
        flush = 1'b1;
        @(negedge ext_clk);
        flush = 1'b0;
        endpoint_ack("zlp", 0, 10);
        check("zlp_no_wren", 32'(wr_n - base), 0);
        check("zlp_pkt_count", 32'(pkt_count), 3);

        // Idle timeout after 5 beats: commit path entered on the 16th idle edge.
        arm_ready("tmo");
        base = wr_n;
        send(3, 5, 1'b0);
        repeat (15) @(negedge ext_clk);
        check("tmo_still_fill", 32'(s_ready), 1);
        @(negedge ext_clk);
        check("tmo_enter_commit", 32'(s_ready), 0);
        check("tmo_commit_not_yet", 32'(ext_buf_in_commit), 0);
        @(negedge ext_clk);
        check("tmo_commit_rise", 32'(ext_buf_in_commit), 1);
        endpoint_ack("tmo", 5, 10);
        check_writes("tmo", base, 3, 5);
        check("tmo_pkt_count", 32'(pkt_count), 4);

        // Reset after 100 beats: packet dropped, outputs cleared at once.
        arm_ready("rstmid");
        rises = commit_rises;
        send(4, 100, 1'b0);
        reset = 1'b1;
        #1;
        check("rstmid_s_ready",    32'(s_ready), 0);
        check("rstmid_wren",       32'(ext_buf_in_wren), 0);
        check("rstmid_addr",       32'(ext_buf_in_addr), 0);
        check("rstmid_data",       32'(ext_buf_in_data), 0);
        check("rstmid_commit",     32'(ext_buf_in_commit), 0);
        check("rstmid_commit_len", 32'(ext_buf_in_commit_len), 0);
        check("rstmid_pkt_count",  32'(pkt_count), 0);
        check("rstmid_busy",       32'(busy), 0);
        repeat (3) @(negedge ext_clk);
        reset = 1'b0;
        check("rstmid_no_commit", 32'(commit_rises - rises), 0);
        arm_ready("post_rst");
        base = wr_n;
        send(5, 3, 1'b1);
        endpoint_ack("post_rst", 3, 10);
        check_writes("post_rst", base, 5, 3);
        check("post_rst_pkt_count", 32'(pkt_count), 1);

        check("wr_commit_overlap", 32'(overlap), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
